uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serial UART transmitter that sits directly downstream of the read controller. It accepts one byte per `txena` request, frames it as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit) and shifts it out on `tx`. While a frame is in flight it holds `txbusy` high; the controller uses that signal to pace `load_txregs`/`shift_txregs` and the next `txena`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868 — clock cycles per bit (100 MHz / 115200 baud); legal range ≥ 2.

Ports:
- `clk`  in  1 — system clock; all logic on rising edge.
- `rst`  in  1 — reset; one clock; reset is synchronous and active-high.
- `txena`  in  1 — transmit request; sampled only in IDLE.
- `txdata`  in  8 — byte to send; captured on the accepting edge.
- `txbusy`  out  1 — 1 while a frame is in flight, 0 in IDLE.
- `tx`  out  1 — serial line, idle high.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `tx`=1, `txbusy`=0. `txena`=1 on an edge → capture `txdata` into shift register, go to START, set `tx`=0 and `txbusy`=1 on that edge.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles → DATA.
- DATA: drive shift-register bit 0 on `tx` for `CLKS_PER_BIT` cycles, shift right, increment 3-bit bit counter; after bit 7 → PARITY (if enabled) else STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles → IDLE, `txbusy`←0 on that same edge.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, cleared at each bit boundary and in IDLE.
- `txena` outside IDLE ignored; no queuing. `txdata` changes after capture do not affect the frame in flight.
- `txena` held high continuously: a new frame starts each time IDLE is reached.
- `rst`: all state to IDLE, `tx`=1, `txbusy`=0, counters and shift register 0 at the next edge; reset mid-frame aborts the frame (line goes high, no partial stop bit). `rst` has priority over `txena`.

## Timing
- Reset values: `tx`=1, `txbusy`=0.
- Outputs are registered; no combinational path from inputs to outputs.
- Accept edge k: `tx`=0, `txbusy`=1 visible after edge k.
- Data bit n (0..7) is driven from edge k+(n+1)·`CLKS_PER_BIT` for `CLKS_PER_BIT` cycles.
- Stop bit begins at edge k+9·`CLKS_PER_BIT`; `txbusy` falls at edge k+10·`CLKS_PER_BIT` (k+11·`CLKS_PER_BIT` with parity).
- `txbusy` low for ≥1 cycle between frames; back-to-back frame period is 10·`CLKS_PER_BIT`+1 cycles (11·`CLKS_PER_BIT`+1 with parity), and `tx` stays 1 in the gap cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after bit 7; `tx` = even parity (XOR of the 8 captured bits) for `CLKS_PER_BIT` cycles; frame is 11 bits.
- Undefined: no PARITY state, no parity logic; 8N1, 10-bit frame.

## Test plan
Run all with `CLKS_PER_BIT`=4.
- Reset: hold `rst` for 2 cycles with `txena`=1 → `tx`=1 and `txbusy`=0 throughout, and no frame starts until `rst` falls.
- Single byte 0xA5: pulse `txena` 1 cycle → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `txbusy` high for exactly 40 cycles.
- Busy ignore: during frame 0x3C, pulse `txena` with `txdata`=0xFF → frame still 0x3C and no second frame.
- Back-to-back: `txena` held high with 0x00 then 0xFF → second start bit begins exactly 41 cycles after the first; `txbusy` low for exactly 1 cycle in between.
- Reset mid-frame: assert `rst` during data bit 3 of 0x00 → `tx`=1 and `txbusy`=0 after that edge; next `txena` sends a clean full frame.
- Parity (macro defined): send 0x07 → 9th bit after start is 1; `txbusy` high for 44 cycles. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity 8E1 frame
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txena,
  input  logic [7:0] txdata,
  output logic       txbusy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_done;
  logic          accept;

  assign bit_done = (baud_cnt == CNT_MAX);
  assign accept   = (state == S_IDLE) && txena;

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  // Even parity of the captured byte, latched with the byte so later txdata changes cannot leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^txdata;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each non-idle state lasts one bit period, DATA repeats for eight bits
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (txena) state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
      S_DATA: begin
        if (bit_done && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP:  if (bit_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from registered state only, so inputs never reach tx/txbusy combinationally
  always_comb begin
    tx     = 1'b1;
    txbusy = 1'b1;
    case (state)
      S_IDLE:   begin tx = 1'b1; txbusy = 1'b0; end
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = par_bit;
`endif
      S_STOP:   tx = 1'b1;
      default:  begin tx = 1'b1; txbusy = 1'b0; end
    endcase
  end

  // Baud counter: runs within a bit period, restarts at every bit boundary and sits at zero in IDLE
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE) || bit_done) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  // Data bit index; wraps back to zero after bit 7 so the next frame starts clean
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE)) begin
      bit_cnt <= 3'd0;
    end else if ((state == S_DATA) && bit_done) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Shift register: load on accept, shift right at the end of every data bit (LSB goes first)
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= 8'h00;
    end else if (accept) begin
      shreg <= txdata;
    end else if ((state == S_DATA) && bit_done) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench for uart_tx_serializer against a frame-timeline model
module tb_uart_tx_serializer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txena = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       txbusy;
  logic       tx;

  int errors = 0;
  int checks = 0;

  // model: a frame is a timeline of FRAME bits, each C cycles, measured from the accept edge
  logic       m_busy = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_el = 0;

  logic samp [0:127];

  uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .txena  (txena),
    .txdata (txdata),
    .txbusy (txbusy),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    return m_busy ? frame_bit(m_byte, m_el / C) : 1'b1;
  endfunction

  // one clock: advance the model on the edge, then compare outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_el   = 0;
    end else if (!m_busy) begin
      if (txena) begin
        m_busy = 1'b1;
        m_byte = txdata;
        m_el   = 0;
      end
    end else begin
      m_el++;
      if (m_el == FRAME * C) begin
        m_busy = 1'b0;
        m_el   = 0;
      end
    end
    #1;
    chk("tx", tx, exp_tx());
    chk("txbusy", txbusy, m_busy);
  endtask

  // accept a byte with a one-cycle txena pulse
  task automatic send(input logic [7:0] b);
    txdata = b;
    txena  = 1'b1;
    tick();
    txena  = 1'b0;
  endtask

  // record tx each cycle while busy; optionally pulse txena=1/txdata=FF at cycle inj
  task automatic run_frame(input int inj, output int n);
    n = 0;
    while (txbusy && n < 128) begin
      samp[n] = tx;
      if (n == inj) begin
        txena  = 1'b1;
        txdata = 8'hFF;
      end else if (n == inj + 1) begin
        txena = 1'b0;
      end
      n++;
      tick();
    end
    if (n >= 128) chk("frame_timeout", 0, 1);
  endtask

  function automatic logic [7:0] decode();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = samp[(i + 1) * C + 1];
    return d;
  endfunction

  initial begin
    int n;
    logic [10:0] seq;

    // reset held 2 cycles with txena high
    rst   = 1'b1;
    txena = 1'b1;
    tick();
    chk("rst_tx0", tx, 1'b1);
    tick();
    chk("rst_busy1", txbusy, 1'b0);
    rst   = 1'b0;
    txena = 1'b0;
    tick();
    chk("post_rst_idle", txbusy, 1'b0);

    // single byte 0xA5
    send(8'hA5);
    run_frame(-10, n);
    chk("a5_busy_len", n, FRAME * C);
`ifdef UART_TX_PARITY_EN
    seq = 11'b01010010101;
`else
    seq = 11'b00101001011;
`endif
    for (int i = 0; i < FRAME; i++) chk("a5_bit", samp[i * C + 2], seq[FRAME - 1 - i]);
    for (int i = 0; i < C; i++) chk("a5_start_hold", samp[i], 1'b0);

    // txena while busy is ignored
    tick();
    send(8'h3C);
    run_frame(13, n);
    chk("ign_len", n, FRAME * C);
    chk("ign_byte", decode(), 8'h3C);
    repeat (6) tick();
    chk("ign_no_second", txbusy, 1'b0);

    // back-to-back with txena held high
    txdata = 8'h00;
    txena  = 1'b1;
    tick();
    txdata = 8'hFF;
    run_frame(-10, n);
    chk("b2b_first_byte", decode(), 8'h00);
    chk("gap_busy", txbusy, 1'b0);
    chk("gap_tx", tx, 1'b1);
    tick();
    chk("b2b_period", n + 1, FRAME * C + 1);
    chk("b2b_restart", txbusy, 1'b1);
    txena = 1'b0;
    run_frame(-10, n);
    chk("b2b_second_byte", decode(), 8'hFF);

    // reset during data bit 3 of 0x00
    tick();
    send(8'h00);
    repeat (4 * C + 1) tick();
    rst = 1'b1;
    tick();
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", txbusy, 1'b0);
    rst = 1'b0;
    tick();
    send(8'h96);
    run_frame(-10, n);
    chk("after_rst_len", n, FRAME * C);
    chk("after_rst_byte", decode(), 8'h96);

`ifdef UART_TX_PARITY_EN
    tick();
    send(8'h07);
    run_frame(-10, n);
    chk("par07_len", n, 44);
    chk("par07_bit", samp[9 * C + 1], 1'b1);
    tick();
    send(8'h03);
    run_frame(-10, n);
    chk("par03_bit", samp[9 * C + 1], 1'b0);
`endif

    // random traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      txena  = ($urandom_range(0, 3) == 0);
      txdata = 8'($urandom);
      tick();
    end
    rst   = 1'b0;
    txena = 1'b0;
    repeat (FRAME * C + 2) tick();
    chk("final_idle", txbusy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
